// File: rtl/c3lib_mux2_arb_ctrl.sv
// Two-requester arbiter for a shared 2:1 mux: moves sel only while no grant is
// active, then waits GAP_CYC dead cycles before granting the new owner.
module c3lib_mux2_arb_ctrl #(
    parameter int GAP_CYC  = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ctrl_en,
    input  logic req0,
    input  logic req1,
    output logic sel,
    output logic gnt0,
    output logic gnt1,
    output logic busy
);

    // state | meaning
    // IDLE  | no owner; sel parked at its last value
    // GAP   | sel just moved toward sel_q; counting dead cycles
    // OWN0  | requester 0 owns the mux (sel = 0)
    // OWN1  | requester 1 owns the mux (sel = 1)
    typedef enum logic [1:0] {IDLE, GAP, OWN0, OWN1} state_t;

    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_q, last_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic        gnt0_q, gnt1_q, busy_q;

    logic        tgt;
    logic        req_tgt;
    logic        own1;
    logic        req_own;
    logic        req_oth;
    logic        preempt;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        gap_cnt_d  = gap_cnt_q;
        hold_cnt_d = hold_cnt_q;
        tgt        = 1'b0;
        req_tgt    = 1'b0;
        own1       = 1'b0;
        req_own    = 1'b0;
        req_oth    = 1'b0;
        preempt    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctrl_en && (req0 || req1)) begin
                    tgt = (req0 && req1) ? ~last_q : req1;
                    if (tgt == sel_q) begin
                        state_d    = tgt ? OWN1 : OWN0;
                        last_d     = tgt;
                        hold_cnt_d = 8'd0;
                    end else begin
                        state_d   = GAP;
                        sel_d     = tgt;
                        gap_cnt_d = 4'd0;
                    end
                end
            end

            // During GAP the target is whatever sel was just moved to.
            GAP: begin
                req_tgt = sel_q ? req1 : req0;
                if (!req_tgt) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d    = sel_q ? OWN1 : OWN0;
                    last_d     = sel_q;
                    hold_cnt_d = 8'd0;
                end else if (gap_cnt_q != 4'hF) begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end

            OWN0, OWN1: begin
                own1    = (state_q == OWN1);
                req_own = own1 ? req1 : req0;
                req_oth = own1 ? req0 : req1;
                preempt = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && req_oth;
                if (!req_own || preempt) begin
                    if (req_oth && ctrl_en) begin
                        state_d   = GAP;
                        sel_d     = ~own1;
                        gap_cnt_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are true flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            gap_cnt_q  <= 4'd0;
            hold_cnt_q <= 8'd0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            gap_cnt_q  <= gap_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            gnt0_q     <= (state_d == OWN0);
            gnt1_q     <= (state_d == OWN1);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign sel  = sel_q;
    assign gnt0 = gnt0_q;
    assign gnt1 = gnt1_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_c3lib_mux2_arb_ctrl.sv
// Directed bench for c3lib_mux2_arb_ctrl: dut_a uses MAX_HOLD=4, dut_b MAX_HOLD=0,
// both driven by the same stimulus; ownership invariants are checked every cycle.
module tb_c3lib_mux2_arb_ctrl;

    logic clk;
    logic rst_n;
    logic ctrl_en;
    logic req0;
    logic req1;
    logic a_sel, a_gnt0, a_gnt1, a_busy;
    logic b_sel, b_gnt0, b_gnt1, b_busy;
    logic a_sel_prev, b_sel_prev;

    int n_tests;
    int n_fail;

    c3lib_mux2_arb_ctrl #(.GAP_CYC(2), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .req0(req0), .req1(req1),
        .sel(a_sel), .gnt0(a_gnt0), .gnt1(a_gnt1), .busy(a_busy)
    );

    c3lib_mux2_arb_ctrl #(.GAP_CYC(2), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ctrl_en(ctrl_en), .req0(req0), .req1(req1),
        .sel(b_sel), .gnt0(b_gnt0), .gnt1(b_gnt1), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        ctrl_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Mutual exclusion, grant/sel agreement, and sel only moving with no grant.
    initial begin
        a_sel_prev = 1'b0;
        b_sel_prev = 1'b0;
    end
    always @(negedge clk) begin
        chk("a_mutex", {7'd0, a_gnt0 & a_gnt1}, 8'd0);
        chk("a_selown", {7'd0, (a_gnt0 & a_sel) | (a_gnt1 & ~a_sel)}, 8'd0);
        chk("b_mutex", {7'd0, b_gnt0 & b_gnt1}, 8'd0);
        chk("b_selown", {7'd0, (b_gnt0 & b_sel) | (b_gnt1 & ~b_sel)}, 8'd0);
        if (a_sel !== a_sel_prev) chk("a_selgnt", {7'd0, a_gnt0 | a_gnt1}, 8'd0);
        if (b_sel !== b_sel_prev) chk("b_selgnt", {7'd0, b_gnt0 | b_gnt1}, 8'd0);
        a_sel_prev = a_sel;
        b_sel_prev = b_sel;
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        ctrl_en = 1'b0;

        // 1: req0 alone with sel already 0 -> grant next cycle, no gap
        do_reset();
        chk("t1_rst_sel", {7'd0, a_sel}, 8'd0);
        chk("t1_rst_gnt0", {7'd0, a_gnt0}, 8'd0);
        chk("t1_rst_gnt1", {7'd0, a_gnt1}, 8'd0);
        chk("t1_rst_busy", {7'd0, a_busy}, 8'd0);
        req0 = 1'b1;
        tick(1);
        chk("t1_c1_gnt0", {7'd0, a_gnt0}, 8'd1);
        chk("t1_c1_sel", {7'd0, a_sel}, 8'd0);
        chk("t1_c1_busy", {7'd0, a_busy}, 8'd1);
        req0 = 1'b0;
        tick(1);
        chk("t1_rel_gnt0", {7'd0, a_gnt0}, 8'd0);
        chk("t1_rel_busy", {7'd0, a_busy}, 8'd0);

        // 2: req1 alone -> sel flips, two dead cycles, grant at cycle 3
        do_reset();
        req1 = 1'b1;
        tick(1);
        chk("t2_c1_sel", {7'd0, a_sel}, 8'd1);
        chk("t2_c1_gnt1", {7'd0, a_gnt1}, 8'd0);
        chk("t2_c1_busy", {7'd0, a_busy}, 8'd1);
        tick(1);
        chk("t2_c2_gnt1", {7'd0, a_gnt1}, 8'd0);
        tick(1);
        chk("t2_c3_gnt1", {7'd0, a_gnt1}, 8'd1);
        chk("t2_c3_sel", {7'd0, a_sel}, 8'd1);
        req1 = 1'b0;
        tick(1);
        chk("t2_rel_gnt1", {7'd0, a_gnt1}, 8'd0);
        chk("t2_rel_sel", {7'd0, a_sel}, 8'd1);

        // 3 (dut_a, preemption) and 4 (dut_b, no preemption): both requests held
        do_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            chk("t4_b_gnt0", {7'd0, b_gnt0}, 8'd1);
            case (c)
                1:  chk("t3_c1_gnt0", {7'd0, a_gnt0}, 8'd1);
                4:  chk("t3_c4_gnt0", {7'd0, a_gnt0}, 8'd1);
                5: begin
                    chk("t3_c5_gnt0", {7'd0, a_gnt0}, 8'd0);
                    chk("t3_c5_sel", {7'd0, a_sel}, 8'd1);
                end
                6:  chk("t3_c6_gnt1", {7'd0, a_gnt1}, 8'd0);
                7:  chk("t3_c7_gnt1", {7'd0, a_gnt1}, 8'd1);
                10: chk("t3_c10_gnt1", {7'd0, a_gnt1}, 8'd1);
                11: begin
                    chk("t3_c11_gnt1", {7'd0, a_gnt1}, 8'd0);
                    chk("t3_c11_sel", {7'd0, a_sel}, 8'd0);
                end
                13: chk("t3_c13_gnt0", {7'd0, a_gnt0}, 8'd1);
                default: ;
            endcase
        end
        req0 = 1'b0;
        tick(1);
        chk("t4_c21_gnt0", {7'd0, b_gnt0}, 8'd0);
        chk("t4_c21_sel", {7'd0, b_sel}, 8'd1);
        tick(1);
        chk("t4_c22_gnt1", {7'd0, b_gnt1}, 8'd0);
        tick(1);
        chk("t4_c23_gnt1", {7'd0, b_gnt1}, 8'd1);

        // 5: target drops during GAP -> back to IDLE, sel stays moved
        do_reset();
        req1 = 1'b1;
        tick(1);
        chk("t5_c1_sel", {7'd0, a_sel}, 8'd1);
        tick(1);
        chk("t5_c2_busy", {7'd0, a_busy}, 8'd1);
        req1 = 1'b0;
        tick(1);
        chk("t5_c3_busy", {7'd0, a_busy}, 8'd0);
        chk("t5_c3_gnt1", {7'd0, a_gnt1}, 8'd0);
        chk("t5_c3_sel", {7'd0, a_sel}, 8'd1);
        tick(2);
        chk("t5_c5_gnt1", {7'd0, a_gnt1}, 8'd0);

        // 6: async reset while OWN1 clears outputs before the next edge
        do_reset();
        req1 = 1'b1;
        tick(3);
        chk("t6_own_gnt1", {7'd0, a_gnt1}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_sel", {7'd0, a_sel}, 8'd0);
        chk("t6_async_gnt1", {7'd0, a_gnt1}, 8'd0);
        chk("t6_async_busy", {7'd0, a_busy}, 8'd0);

        // 7: ctrl_en gates new grants only
        do_reset();
        ctrl_en = 1'b0;
        req0    = 1'b1;
        tick(3);
        chk("t7_dis_gnt0", {7'd0, a_gnt0}, 8'd0);
        chk("t7_dis_busy", {7'd0, a_busy}, 8'd0);
        ctrl_en = 1'b1;
        tick(1);
        chk("t7_en_gnt0", {7'd0, a_gnt0}, 8'd1);
        ctrl_en = 1'b0;
        tick(3);
        chk("t7_hold_gnt0", {7'd0, a_gnt0}, 8'd1);
        req0 = 1'b0;
        tick(1);
        chk("t7_rel_gnt0", {7'd0, a_gnt0}, 8'd0);
        chk("t7_rel_busy", {7'd0, a_busy}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
